// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap unit: CSR addresses, cause
// codes, CSR write-mode encodings and the trap sequencer state type.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned IRQ_BASE         = 16;

  localparam logic [4:0] CAUSE_ILLEGAL     = 5'd2;
  localparam logic [4:0] CAUSE_LOAD_FAULT  = 5'd5;
  localparam logic [4:0] CAUSE_STORE_FAULT = 5'd7;
  localparam logic [4:0] CAUSE_ECALL_M     = 5'd11;

  typedef enum logic [1:0] {
    WSC_NONE  = 2'b00,
    WSC_WRITE = 2'b01,
    WSC_SET   = 2'b10,
    WSC_CLEAR = 2'b11
  } wsc_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TAKE  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Interrupt cause code for external line idx.
  function automatic logic [4:0] irq_code(input logic [3:0] idx);
    return 5'(IRQ_BASE) + {1'b0, idx};
  endfunction

endpackage

// File: rtl/trap_csr_file.sv
// Machine-mode trap CSR storage, combinational read mux and write/set/clear
// logic. Vectored mtvec mode is compiled in with TRAP_VECTORED_EN.
module trap_csr_file
  import trap_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_IRQ = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                csr_we,
  input  logic [1:0]          csr_wsc_mode,
  input  logic [11:0]         csr_addr,
  input  logic [XLEN-1:0]     csr_wdata,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic                trap_take,
  input  logic [XLEN-1:0]     trap_epc,
  input  logic [XLEN-1:0]     trap_cause,
  input  logic [XLEN-1:0]     trap_tval,
  input  logic                mret_take,
  output logic [XLEN-1:0]     csr_rdata,
  output logic                mie_en,
  output logic [NUM_IRQ-1:0]  mie_bits,
  output logic [XLEN-1:0]     mtvec_val,
  output logic [XLEN-1:0]     mepc_val
);

  logic               status_mie;
  logic               status_mpie;
  logic [NUM_IRQ-1:0] mie_q;
  logic [XLEN-1:2]    mtvec_base;
  logic               mtvec_vec;
  logic [XLEN-1:2]    mepc_hi;
  logic [XLEN-1:0]    mcause_q;
  logic [XLEN-1:0]    mtval_q;
  logic [XLEN-1:0]    rd_val;
  logic [XLEN-1:0]    wr_val;

  // mepc is word aligned; the low PC bits are dropped on capture.
  logic unused_epc;
  assign unused_epc = ^trap_epc[1:0];

  assign mie_en    = status_mie;
  assign mie_bits  = mie_q;
  assign mtvec_val = {mtvec_base, 1'b0, mtvec_vec};
  assign mepc_val  = {mepc_hi, 2'b00};
  assign csr_rdata = rd_val;

  // Combinational read of the addressed CSR; unmapped addresses read zero.
  always_comb begin
    rd_val = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        rd_val[MSTATUS_MIE_BIT]  = status_mie;
        rd_val[MSTATUS_MPIE_BIT] = status_mpie;
      end
      CSR_MIE:    rd_val[IRQ_BASE +: NUM_IRQ] = mie_q;
      CSR_MIP:    rd_val[IRQ_BASE +: NUM_IRQ] = irq;
      CSR_MTVEC:  rd_val = mtvec_val;
      CSR_MEPC:   rd_val = mepc_val;
      CSR_MCAUSE: rd_val = mcause_q;
      CSR_MTVAL:  rd_val = mtval_q;
      default:    rd_val = '0;
    endcase
  end

  // New CSR value: set/clear act bitwise on the value currently read back.
  always_comb begin
    wr_val = rd_val;
    case (wsc_e'(csr_wsc_mode))
      WSC_WRITE: wr_val = csr_wdata;
      WSC_SET:   wr_val = rd_val | csr_wdata;
      WSC_CLEAR: wr_val = rd_val & ~csr_wdata;
      default:   wr_val = rd_val;
    endcase
  end

  // CSR state: trap entry, mret, then software writes (mutually exclusive).
  always_ff @(posedge clk) begin
    if (rst) begin
      status_mie  <= 1'b0;
      status_mpie <= 1'b0;
      mie_q       <= '0;
      mtvec_base  <= '0;
      mtvec_vec   <= 1'b0;
      mepc_hi     <= '0;
      mcause_q    <= '0;
      mtval_q     <= '0;
    end else if (trap_take) begin
      mepc_hi     <= trap_epc[XLEN-1:2];
      mcause_q    <= trap_cause;
      mtval_q     <= trap_tval;
      status_mpie <= status_mie;
      status_mie  <= 1'b0;
    end else if (mret_take) begin
      status_mie  <= status_mpie;
      status_mpie <= 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          status_mie  <= wr_val[MSTATUS_MIE_BIT];
          status_mpie <= wr_val[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:    mie_q <= wr_val[IRQ_BASE +: NUM_IRQ];
        CSR_MTVEC: begin
          mtvec_base <= wr_val[XLEN-1:2];
`ifdef TRAP_VECTORED_EN
          // Reserved modes 10/11 collapse to direct mode.
          mtvec_vec  <= (wr_val[1:0] == 2'b01);
`else
          mtvec_vec  <= 1'b0;
`endif
        end
        CSR_MEPC:   mepc_hi  <= wr_val[XLEN-1:2];
        CSR_MCAUSE: mcause_q <= wr_val;
        CSR_MTVAL:  mtval_q  <= wr_val;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/trap_unit.sv
// Machine-mode trap unit: event prioritisation, trap/mret sequencer and
// pipeline redirect/flush control. Define TRAP_VECTORED_EN for vectored
// interrupt targets.
module trap_unit
  import trap_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_IRQ = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                csr_rw,
  input  logic [1:0]          csr_wsc_mode,
  input  logic [11:0]         csr_addr,
  input  logic [XLEN-1:0]     csr_wdata,
  output logic [XLEN-1:0]     csr_rdata,
  input  logic                illegal_inst,
  input  logic                ecall_m,
  input  logic                l_access_fault,
  input  logic                s_access_fault,
  input  logic                mret,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic [XLEN-1:0]     epc_cur,
  input  logic [XLEN-1:0]     epc_next,
  input  logic [XLEN-1:0]     fault_addr,
  output logic [XLEN-1:0]     PC_redirect,
  output logic                redirect_mux,
  output logic                reg_FD_flush,
  output logic                reg_DE_flush,
  output logic                reg_EM_flush,
  output logic                reg_MW_flush,
  output logic                RegWrite_cancel,
  output logic                busy
);

  state_e             state;
  logic               take_q;
  logic               busy_q;
  logic [XLEN-1:0]    pc_q;

  logic               mie_en;
  logic [NUM_IRQ-1:0] mie_bits;
  logic [XLEN-1:0]    mtvec_val;
  logic [XLEN-1:0]    mepc_val;

  logic [NUM_IRQ-1:0] irq_hit;
  logic               irq_found;
  logic [3:0]         irq_idx;

  logic               ev_exc;
  logic               ev_irq;
  logic               ev_mret;
  logic [XLEN-1:0]    ev_cause;
  logic [XLEN-1:0]    ev_tval;
  logic [XLEN-1:0]    ev_epc;

  logic               in_idle;
  logic               trap_take;
  logic               mret_take;
  logic               csr_we;
  logic [XLEN-1:0]    trap_base;
  logic [XLEN-1:0]    trap_target;

  // Lowest-numbered enabled pending interrupt line.
  always_comb begin
    irq_hit   = irq & mie_bits;
    irq_found = 1'b0;
    irq_idx   = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (!irq_found && irq_hit[i]) begin
        irq_found = 1'b1;
        irq_idx   = 4'(i);
      end
    end
  end

  // Fixed-priority event selection with cause, tval and return PC.
  always_comb begin
    ev_exc   = 1'b0;
    ev_irq   = 1'b0;
    ev_mret  = 1'b0;
    ev_cause = '0;
    ev_tval  = '0;
    ev_epc   = epc_cur;
    if (illegal_inst) begin
      ev_exc        = 1'b1;
      ev_cause[4:0] = CAUSE_ILLEGAL;
    end else if (ecall_m) begin
      ev_exc        = 1'b1;
      ev_cause[4:0] = CAUSE_ECALL_M;
    end else if (l_access_fault) begin
      ev_exc        = 1'b1;
      ev_cause[4:0] = CAUSE_LOAD_FAULT;
      ev_tval       = fault_addr;
    end else if (s_access_fault) begin
      ev_exc        = 1'b1;
      ev_cause[4:0] = CAUSE_STORE_FAULT;
      ev_tval       = fault_addr;
    end else if (mie_en && irq_found) begin
      ev_irq           = 1'b1;
      ev_cause[XLEN-1] = 1'b1;
      ev_cause[4:0]    = irq_code(irq_idx);
      ev_epc           = epc_next;
    end else if (mret) begin
      ev_mret = 1'b1;
    end
  end

  assign in_idle   = (state == ST_IDLE);
  assign trap_take = in_idle && (ev_exc || ev_irq);
  assign mret_take = in_idle && ev_mret;
  assign csr_we    = in_idle && !(ev_exc || ev_irq || ev_mret) &&
                     csr_rw && (csr_wsc_mode != WSC_NONE);
  assign trap_base = {mtvec_val[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  // Vectored mode offsets interrupts only; exceptions always go to base.
  always_comb begin
    trap_target = trap_base;
    if (ev_irq && (mtvec_val[1:0] == 2'b01))
      trap_target = trap_base + XLEN'({irq_code(irq_idx), 2'b00});
  end
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec_val[1:0];
  assign trap_target       = trap_base;
`endif

  trap_csr_file #(
    .XLEN    (XLEN),
    .NUM_IRQ (NUM_IRQ)
  ) u_csr (
    .clk          (clk),
    .rst          (rst),
    .csr_we       (csr_we),
    .csr_wsc_mode (csr_wsc_mode),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .irq          (irq),
    .trap_take    (trap_take),
    .trap_epc     (ev_epc),
    .trap_cause   (ev_cause),
    .trap_tval    (ev_tval),
    .mret_take    (mret_take),
    .csr_rdata    (csr_rdata),
    .mie_en       (mie_en),
    .mie_bits     (mie_bits),
    .mtvec_val    (mtvec_val),
    .mepc_val     (mepc_val)
  );

  // Trap sequencer IDLE -> TAKE -> DRAIN with registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      take_q <= 1'b0;
      busy_q <= 1'b0;
      pc_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trap_take || mret_take) begin
            state  <= ST_TAKE;
            take_q <= 1'b1;
            busy_q <= 1'b1;
            pc_q   <= mret_take ? mepc_val : trap_target;
          end
        end
        ST_TAKE: begin
          state  <= ST_DRAIN;
          take_q <= 1'b0;
        end
        ST_DRAIN: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          take_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign PC_redirect     = pc_q;
  assign redirect_mux    = take_q;
  assign reg_FD_flush    = take_q;
  assign reg_DE_flush    = take_q;
  assign reg_EM_flush    = take_q;
  assign reg_MW_flush    = take_q;
  assign RegWrite_cancel = take_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_trap_unit.sv
// Self-checking bench for trap_unit: directed trap/mret/reset scenarios and
// randomized traffic compared against a behavioural model of the CSR/trap rules.
module tb_trap_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_rw = 1'b0;
  logic [1:0]  csr_wsc_mode = 2'b00;
  logic [11:0] csr_addr = 12'h000;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        illegal_inst = 1'b0, ecall_m = 1'b0, l_access_fault = 1'b0;
  logic        s_access_fault = 1'b0, mret = 1'b0;
  logic [3:0]  irq = 4'b0;
  logic [31:0] epc_cur = '0, epc_next = '0, fault_addr = '0;
  logic [31:0] PC_redirect;
  logic        redirect_mux, reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush;
  logic        RegWrite_cancel, busy;

  always #10 clk = ~clk;

  trap_unit #(.XLEN(32), .NUM_IRQ(4)) dut (
    .clk(clk), .rst(rst), .csr_rw(csr_rw), .csr_wsc_mode(csr_wsc_mode),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .illegal_inst(illegal_inst), .ecall_m(ecall_m), .l_access_fault(l_access_fault),
    .s_access_fault(s_access_fault), .mret(mret), .irq(irq),
    .epc_cur(epc_cur), .epc_next(epc_next), .fault_addr(fault_addr),
    .PC_redirect(PC_redirect), .redirect_mux(redirect_mux),
    .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush),
    .reg_EM_flush(reg_EM_flush), .reg_MW_flush(reg_MW_flush),
    .RegWrite_cancel(RegWrite_cancel), .busy(busy)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Behavioural model: architectural CSR values plus cycles into a trap sequence.
  bit          m_mie = 0, m_mpie = 0;
  logic [3:0]  m_mier = '0;
  logic [31:0] m_mtvec = '0, m_mepc = '0, m_mcause = '0, m_mtval = '0, m_pc = '0;
  int          m_phase = 0;

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return (32'(m_mie) << 3) | (32'(m_mpie) << 7);
      12'h304: return 32'(m_mier) << 16;
      12'h344: return 32'(irq) << 16;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    bit exc, intr;
    int idx;
    logic [31:0] c, tv, cur, nv, base;
    if (rst) begin
      m_mie = 0; m_mpie = 0; m_mier = '0; m_mtvec = '0; m_mepc = '0;
      m_mcause = '0; m_mtval = '0; m_pc = '0; m_phase = 0;
      return;
    end
    if (m_phase == 1) begin m_phase = 2; return; end
    if (m_phase == 2) begin m_phase = 0; return; end
    exc = 0; intr = 0; idx = 0; c = 0; tv = 0;
    base = m_mtvec & ~32'h3;
    if (illegal_inst)        begin exc = 1; c = 2; end
    else if (ecall_m)        begin exc = 1; c = 11; end
    else if (l_access_fault) begin exc = 1; c = 5; tv = fault_addr; end
    else if (s_access_fault) begin exc = 1; c = 7; tv = fault_addr; end
    else if (m_mie && ((irq & m_mier) != 0)) begin
      intr = 1;
      for (int i = 3; i >= 0; i--) if (irq[i] && m_mier[i]) idx = i;
      c = 32'h8000_0000 | 32'(16 + idx);
    end
    if (exc || intr) begin
      m_mepc   = (exc ? epc_cur : epc_next) & ~32'h3;
      m_mcause = c;
      m_mtval  = tv;
      m_mpie   = m_mie;
      m_mie    = 0;
      m_pc     = base;
`ifdef TRAP_VECTORED_EN
      if (intr && (m_mtvec & 32'h3) == 32'h1) m_pc = base + 32'(4 * (16 + idx));
`endif
      m_phase = 1;
    end else if (mret) begin
      m_pc = m_mepc; m_mie = m_mpie; m_mpie = 1; m_phase = 1;
    end else if (csr_rw && csr_wsc_mode != 2'b00) begin
      cur = model_read(csr_addr);
      nv = (csr_wsc_mode == 2'b01) ? csr_wdata :
           (csr_wsc_mode == 2'b10) ? (cur | csr_wdata) : (cur & ~csr_wdata);
      case (csr_addr)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mier = nv[19:16];
`ifdef TRAP_VECTORED_EN
        12'h305: m_mtvec = (nv & ~32'h3) | ((nv[1:0] == 2'b01) ? 32'h1 : 32'h0);
`else
        12'h305: m_mtvec = nv & ~32'h3;
`endif
        12'h341: m_mepc = nv & ~32'h3;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    check("pc_redirect", PC_redirect, m_pc);
    check("take_outputs", {26'b0, redirect_mux, reg_FD_flush, reg_DE_flush,
                           reg_EM_flush, reg_MW_flush, RegWrite_cancel},
          (m_phase == 1) ? 32'h3f : 32'h0);
    check("busy", {31'b0, busy}, (m_phase != 0) ? 32'h1 : 32'h0);
    check("csr_rdata", csr_rdata, model_read(csr_addr));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [1:0] mode, input logic [31:0] d);
    csr_rw = 1'b1; csr_addr = a; csr_wsc_mode = mode; csr_wdata = d;
    tick();
    csr_rw = 1'b0; csr_wsc_mode = 2'b00;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  logic [11:0] addr_pool [8] = '{12'h300, 12'h304, 12'h305, 12'h341,
                                 12'h342, 12'h343, 12'h344, 12'h7ff};
  logic [31:0] vec_exp_pc, vec_exp_tvec;

  initial begin
`ifdef TRAP_VECTORED_EN
    vec_exp_pc = 32'h240; vec_exp_tvec = 32'h201;
`else
    vec_exp_pc = 32'h200; vec_exp_tvec = 32'h200;
`endif
    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rd("reset_csr", addr_pool[i], 32'h0);
      tick();
    end

    // Illegal instruction to direct mtvec
    csr_write(12'h305, 2'b01, 32'h100);
    illegal_inst = 1'b1; epc_cur = 32'h40;
    tick();
    illegal_inst = 1'b0;
    check("illegal_redirect", PC_redirect, 32'h100);
    check("illegal_flush", {31'b0, reg_FD_flush}, 32'h1);
    rd("illegal_mepc", 12'h341, 32'h40);
    rd("illegal_mcause", 12'h342, 32'h2);
    tick();
    check("drain_no_flush", {31'b0, redirect_mux}, 32'h0);
    check("drain_busy", {31'b0, busy}, 32'h1);
    tick();
    check("idle_after_n3", {31'b0, busy}, 32'h0);

    // ecall beats load fault
    ecall_m = 1'b1; l_access_fault = 1'b1; fault_addr = 32'h8;
    tick();
    ecall_m = 1'b0; l_access_fault = 1'b0;
    rd("ecall_mcause", 12'h342, 32'd11);
    rd("ecall_mtval", 12'h343, 32'h0);
    tick(); tick();

    // Interrupt entry, lowest enabled line
    csr_write(12'h304, 2'b01, 32'h0006_0000);
    csr_write(12'h300, 2'b01, 32'h8);
    irq = 4'b0110; epc_next = 32'h24;
    tick();
    irq = 4'b0000;
    rd("irq_mcause", 12'h342, 32'h8000_0011);
    rd("irq_mepc", 12'h341, 32'h24);
    rd("irq_mstatus", 12'h300, 32'h80);
    tick(); tick();

    // mret returns and restores MIE
    mret = 1'b1;
    tick();
    mret = 1'b0;
    check("mret_redirect", PC_redirect, 32'h24);
    rd("mret_mstatus", 12'h300, 32'h88);
    tick(); tick();
    csr_write(12'h300, 2'b11, 32'h8);
    irq = 4'b0110;
    tick(); tick();
    check("irq_masked_no_trap", {31'b0, busy}, 32'h0);
    irq = 4'b0000;

    // Vectored interrupt target
    csr_write(12'h305, 2'b01, 32'h201);
    csr_write(12'h304, 2'b10, 32'h0001_0000);
    csr_write(12'h300, 2'b10, 32'h8);
    irq = 4'b0001;
    tick();
    irq = 4'b0000;
    check("vector_redirect", PC_redirect, vec_exp_pc);
    rd("vector_mcause", 12'h342, 32'h8000_0010);
    tick(); tick();

    // Write concurrent with event dropped; reset aborts TAKE
    illegal_inst = 1'b1;
    csr_rw = 1'b1; csr_addr = 12'h305; csr_wsc_mode = 2'b01; csr_wdata = 32'h300;
    tick();
    illegal_inst = 1'b0; csr_rw = 1'b0; csr_wsc_mode = 2'b00;
    rd("dropped_write", 12'h305, vec_exp_tvec);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_take_busy", {31'b0, busy}, 32'h0);
    check("rst_take_pc", PC_redirect, 32'h0);
    for (int i = 0; i < 7; i++) begin
      rd("rst_take_csr", addr_pool[i], 32'h0);
      tick();
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 199) == 0);
      illegal_inst   = ($urandom_range(0, 19) == 0);
      ecall_m        = ($urandom_range(0, 19) == 0);
      l_access_fault = ($urandom_range(0, 19) == 0);
      s_access_fault = ($urandom_range(0, 19) == 0);
      mret           = ($urandom_range(0, 15) == 0);
      irq            = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      csr_rw         = $urandom_range(0, 1) == 1;
      csr_wsc_mode   = 2'($urandom);
      csr_addr       = addr_pool[$urandom_range(0, 7)];
      csr_wdata      = $urandom;
      epc_cur        = $urandom;
      epc_next       = $urandom;
      fault_addr     = $urandom;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
